// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port RAM between the CPU port and an external
// loader/DMA port. One grant per clock, combinational arbitration, 1-cycle read
// valid strobe back to the winner.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for alternating (round-robin)
// resolution of unlocked conflicts; default build uses fixed CPU priority.
module mem_arbiter #(
  parameter int unsigned word_size = 8,
  parameter int unsigned addr_size = 8,
  parameter int unsigned max_burst = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  // CPU port
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [addr_size-1:0] cpu_addr,
  input  logic [word_size-1:0] cpu_wdata,
  output logic                 cpu_gnt,
  output logic                 cpu_rvalid,
  output logic [word_size-1:0] cpu_rdata,
  // External loader port
  input  logic                 ext_req,
  input  logic                 ext_we,
  input  logic [addr_size-1:0] ext_addr,
  input  logic [word_size-1:0] ext_wdata,
  input  logic                 ext_lock,
  output logic                 ext_gnt,
  output logic                 ext_rvalid,
  output logic [word_size-1:0] ext_rdata,
  // RAM side
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [addr_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_wdata,
  input  logic [word_size-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCpu  = 2'd1,
    StExt  = 2'd2
  } owner_e;

  localparam logic [3:0] MaxBurst = 4'(max_burst);
  localparam logic       WinCpu   = 1'b0;
  localparam logic       WinExt   = 1'b1;

  owner_e     owner_q, owner_d;
  logic       last_win_q, last_win_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       cpu_rvalid_q, cpu_rvalid_d;
  logic       ext_rvalid_q, ext_rvalid_d;
  logic       burst_ok;

  assign burst_ok = (owner_q == StExt) && ext_lock && (burst_cnt_q < MaxBurst);

  // Pick the winner for this cycle; nothing is granted while reset is held.
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    if (!rst) begin
      if (cpu_req && ext_req) begin
        if (burst_ok) begin
          ext_gnt = 1'b1;
        end else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          // Alternate: serve whoever did not win last time.
          if (last_win_q == WinExt) begin
            cpu_gnt = 1'b1;
          end else begin
            ext_gnt = 1'b1;
          end
`else
          cpu_gnt = 1'b1;
`endif
        end
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (ext_req) begin
        ext_gnt = 1'b1;
      end
    end
  end

  // Steer the winner's request onto the RAM; all zero when idle.
  always_comb begin
    mem_en    = cpu_gnt | ext_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ext_gnt) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  // Next owner, last winner, burst counter and read-valid strobes.
  always_comb begin
    owner_d      = StIdle;
    last_win_d   = last_win_q;
    burst_cnt_d  = burst_cnt_q;
    cpu_rvalid_d = cpu_gnt & ~cpu_we;
    ext_rvalid_d = ext_gnt & ~ext_we;

    if (cpu_gnt) begin
      owner_d    = StCpu;
      last_win_d = WinCpu;
    end else if (ext_gnt) begin
      owner_d    = StExt;
      last_win_d = WinExt;
    end

    // Counts only ext grants that held off a waiting CPU; saturates at the limit.
    if (cpu_gnt || !ext_req) begin
      burst_cnt_d = '0;
    end else if (ext_gnt && cpu_req && (burst_cnt_q < MaxBurst)) begin
      burst_cnt_d = burst_cnt_q + 4'd1;
    end
  end

  // State registers; last_win resets to EXT so the first conflict goes to the CPU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= StIdle;
      last_win_q   <= WinExt;
      burst_cnt_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      last_win_q   <= last_win_d;
      burst_cnt_q  <= burst_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ext_rvalid_q <= ext_rvalid_d;
    end
  end

  // Mask strobes with reset so a pending read valid never escapes a reset.
  assign cpu_rvalid = cpu_rvalid_q & ~rst;
  assign ext_rvalid = ext_rvalid_q & ~rst;
  assign cpu_rdata  = mem_rdata;
  assign ext_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// checked against a rule-level reference model. Includes a behavioural RAM.
module tb_mem_arbiter;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0;
  logic       cpu_gnt, cpu_rvalid;
  logic [7:0] cpu_rdata;
  logic       ext_req = 1'b0, ext_we = 1'b0, ext_lock = 1'b0;
  logic [7:0] ext_addr = '0, ext_wdata = '0;
  logic       ext_gnt, ext_rvalid;
  logic [7:0] ext_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;

  logic [7:0] ram [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.word_size(8), .addr_size(8), .max_burst(MAXB)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_lock(ext_lock), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Behavioural single-port RAM with registered read data.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0; ext_lock = 0;
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    cpu_req = 1; ext_req = 1; cpu_addr = 8'h33;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, mem_en, mem_we, mem_addr, mem_wdata}
          !== 22'd0) begin
        errors++;
        $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b en=%b we=%b a=%h d=%h want all 0",
                 cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, mem_en, mem_we, mem_addr, mem_wdata);
      end
    end
    idle_inputs();
    @(negedge clk); rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b0) begin
        errors++;
        $display("FAIL idle_mem_en: cycle %0d got %b want 0", i, mem_en);
      end
    end
    next_cycle();
  endtask

  // Both read every cycle without lock, starting from fresh reset state.
  task automatic test_conflict();
    logic prev_cpu, exp_cpu;
    prev_cpu = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01;
    ext_req = 1; ext_we = 0; ext_addr = 8'h02; ext_lock = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_cpu = (i % 2 == 0);
`else
      exp_cpu = 1'b1;
`endif
      checks++;
      if ({cpu_gnt, ext_gnt} !== {exp_cpu, ~exp_cpu}) begin
        errors++;
        $display("FAIL conflict_gnt: cycle %0d got cpu=%b ext=%b want cpu=%b ext=%b",
                 i, cpu_gnt, ext_gnt, exp_cpu, ~exp_cpu);
      end
      if (i > 0) begin
        checks++;
        if ({cpu_rvalid, ext_rvalid} !== {prev_cpu, ~prev_cpu}) begin
          errors++;
          $display("FAIL conflict_rvalid: cycle %0d got cpu=%b ext=%b want cpu=%b ext=%b",
                   i, cpu_rvalid, ext_rvalid, prev_cpu, ~prev_cpu);
        end
      end
      prev_cpu = exp_cpu;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_ext_write_read();
    idle_inputs();
    ext_req = 1; ext_we = 1; ext_addr = 8'd128; ext_wdata = 8'd6;
    @(negedge clk);
    checks++;
    if ({ext_gnt, cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b1011, 8'd128, 8'd6}) begin
      errors++;
      $display("FAIL ext_write: got gnt=%b cg=%b en=%b we=%b a=%0d d=%0d want 1 0 1 1 128 6",
               ext_gnt, cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    next_cycle();
    ext_we = 0;
    @(negedge clk);
    checks++;
    if ({ext_gnt, mem_we, mem_addr, ext_rvalid} !== {2'b10, 8'd128, 1'b0}) begin
      errors++;
      $display("FAIL ext_read_gnt: got gnt=%b we=%b a=%0d rv=%b want 1 0 128 0",
               ext_gnt, mem_we, mem_addr, ext_rvalid);
    end
    next_cycle();
    ext_req = 0;
    @(negedge clk);
    checks++;
    if ({ext_rvalid, cpu_rvalid, ext_rdata} !== {2'b10, 8'd6}) begin
      errors++;
      $display("FAIL ext_read_data: got rv=%b crv=%b d=%0d want 1 0 6",
               ext_rvalid, cpu_rvalid, ext_rdata);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({ext_rvalid, cpu_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL ext_rvalid_width: got rv=%b crv=%b want 0 0", ext_rvalid, cpu_rvalid);
    end
    next_cycle();
  endtask

  // Ext takes ownership, then CPU contends; expect MAXB ext grants, then CPU.
  // Run twice to show the counter restarts after the CPU is served.
  task automatic test_lock_burst();
    int n_ext;
    bit got_cpu;
    for (int rep = 0; rep < 2; rep++) begin
      idle_inputs();
      ext_req = 1; ext_lock = 1; ext_addr = 8'h20;
      next_cycle();
      cpu_req = 1; cpu_addr = 8'h40;
      n_ext = 0; got_cpu = 0;
      for (int i = 0; i < 10 && !got_cpu; i++) begin
        @(negedge clk);
        if (cpu_gnt) got_cpu = 1;
        else if (ext_gnt) n_ext++;
        next_cycle();
        ext_addr = ext_addr + 1;
      end
      checks++;
      if (!got_cpu || n_ext != MAXB) begin
        errors++;
        $display("FAIL lock_burst: rep %0d got %0d ext grants cpu_served=%0d want %0d 1",
                 rep, n_ext, got_cpu, MAXB);
      end
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    cpu_req = 1; cpu_addr = 8'd130;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, mem_addr} !== {1'b1, 8'd130}) begin
      errors++;
      $display("FAIL rmid_gnt: got gnt=%b a=%0d want 1 130", cpu_gnt, mem_addr);
    end
    @(posedge clk);
    rst = 1;
    #1;
    checks++;
    if ({cpu_rvalid, mem_en} !== 2'b00) begin
      errors++;
      $display("FAIL rmid_immediate: got rv=%b en=%b want 0 0", cpu_rvalid, mem_en);
    end
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, mem_en, cpu_gnt} !== 3'b000) begin
      errors++;
      $display("FAIL rmid_held: got rv=%b en=%b gnt=%b want 0 0 0", cpu_rvalid, mem_en, cpu_gnt);
    end
    next_cycle();
    rst = 0; cpu_req = 0;
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_after: got rv=%b want 0", cpu_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_cancel();
    bit bad;
    bad = 0;
    idle_inputs();
    ext_req = 1; ext_lock = 1; ext_addr = 8'h10;
    next_cycle();
    cpu_req = 1; cpu_addr = 8'h55;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) cpu_req = 0;
      @(negedge clk);
      if (cpu_gnt || cpu_rvalid || mem_addr == 8'h55 || !ext_gnt) bad = 1;
      next_cycle();
      ext_addr = ext_addr + 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL cancel: got cpu access or lost ext grant, want no cpu access");
    end
    idle_inputs();
    next_cycle();
  endtask

  // Randomized traffic against a rule-level model of the arbiter and RAM.
  task automatic test_random();
    logic [7:0] ref_mem [256];
    int owner, last, cnt, w;   // 0 none, 1 cpu, 2 ext
    bit exp_crv, exp_erv, c_req, e_req, c_we, e_we, lk;
    logic [7:0] c_addr, e_addr, c_wd, e_wd, exp_rd, ea;
    int bad_before;
    idle_inputs();
    rst = 1; next_cycle(); rst = 0;
    for (int a = 0; a < 256; a++) ref_mem[a] = ram[a];
    owner = 0; last = 2; cnt = 0; exp_crv = 0; exp_erv = 0; exp_rd = 0;
    c_req = 0; e_req = 0; c_we = 0; e_we = 0; lk = 0;
    c_addr = 0; e_addr = 0; c_wd = 0; e_wd = 0;
    bad_before = errors;
    for (int i = 0; i < 500; i++) begin
      if (c_req && $urandom_range(0, 7) == 0) c_req = 0;
      else if (!c_req && $urandom_range(0, 1) == 1) begin
        c_req = 1; c_we = 1'($urandom_range(0, 1));
        c_addr = 8'($urandom_range(0, 15)); c_wd = 8'($urandom);
      end
      if (e_req && $urandom_range(0, 7) == 0) e_req = 0;
      else if (!e_req && $urandom_range(0, 3) != 0) begin
        e_req = 1; e_we = 1'($urandom_range(0, 1));
        e_addr = 8'($urandom_range(0, 15)); e_wd = 8'($urandom);
      end
      if ($urandom_range(0, 5) == 0) lk = ~lk;
      cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
      ext_req = e_req; ext_we = e_we; ext_addr = e_addr; ext_wdata = e_wd; ext_lock = lk;

      if (c_req && e_req) begin
        if (owner == 2 && lk && cnt < MAXB) w = 2;
        else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          w = (last == 1) ? 2 : 1;
`else
          w = 1;
`endif
        end
      end else if (c_req) w = 1;
      else if (e_req) w = 2;
      else w = 0;
      ea = (w == 1) ? c_addr : (w == 2) ? e_addr : 8'd0;

      @(negedge clk);
      checks++;
      if ({cpu_gnt, ext_gnt, mem_en} !== {w == 1, w == 2, w != 0} || mem_addr !== ea) begin
        errors++;
        $display("FAIL rnd_gnt: cycle %0d got c=%b e=%b en=%b a=%h want c=%b e=%b a=%h",
                 i, cpu_gnt, ext_gnt, mem_en, mem_addr, w == 1, w == 2, ea);
      end
      checks++;
      if (w != 0 && (mem_we !== ((w == 1) ? c_we : e_we) ||
                     mem_wdata !== ((w == 1) ? c_wd : e_wd))) begin
        errors++;
        $display("FAIL rnd_wr: cycle %0d got we=%b d=%h", i, mem_we, mem_wdata);
      end
      checks++;
      if ({cpu_rvalid, ext_rvalid} !== {exp_crv, exp_erv} ||
          (exp_crv && cpu_rdata !== exp_rd) || (exp_erv && ext_rdata !== exp_rd)) begin
        errors++;
        $display("FAIL rnd_rd: cycle %0d got rv=%b%b cd=%h ed=%h want rv=%b%b d=%h",
                 i, cpu_rvalid, ext_rvalid, cpu_rdata, ext_rdata, exp_crv, exp_erv, exp_rd);
      end
      if (errors - bad_before > 10) break;

      exp_crv = (w == 1) && !c_we;
      exp_erv = (w == 2) && !e_we;
      if (w != 0) begin
        if ((w == 1) ? c_we : e_we) ref_mem[ea] = (w == 1) ? c_wd : e_wd;
        else exp_rd = ref_mem[ea];
      end
      if (w == 1 || !e_req) cnt = 0;
      else if (w == 2 && c_req && cnt < MAXB) cnt++;
      owner = w;
      if (w != 0) last = w;
      next_cycle();
      if (w == 1) c_req = 0;
      if (w == 2) e_req = 0;
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) ram[a] = 8'(a ^ 8'hA5);
    test_reset();
    test_conflict();
    test_ext_write_read();
    test_lock_burst();
    test_reset_mid();
    test_cancel();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
